pipe_hazard_ctrl: RTL

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. Replaces the fixed, purely combinational 3-source register-forwarding mux.
- Tracks destination tags through STAGES post-decode stages (EX..WB) and forwards the youngest matching result to NUM_RS decode read ports.
- Detects load-use hazards, stalls ID, inserts an EX bubble, applies flushes, and drives register-file writeback.
- Sits between ID, the 32x32 register file and the EX/MEM/WB datapath.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller.
//   PKG_XLEN / PKG_REG_AW : default datapath and register-address widths
//   EX_STG / MEM_STG      : indices of the EX and MEM stages in the tag pipe
//   hz_tag_t              : per-stage destination tag
//   tag_writes()          : "this stage will write register a" predicate
package pipe_hazard_ctrl_pkg;

  localparam int unsigned PKG_XLEN   = 32;
  localparam int unsigned PKG_REG_AW = 5;

  localparam int unsigned EX_STG  = 0;
  localparam int unsigned MEM_STG = 1;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [PKG_REG_AW-1:0] addr;
    logic                  is_load;
  } hz_tag_t;

  localparam int unsigned TAG_W      = $bits(hz_tag_t);
  localparam hz_tag_t     BUBBLE_TAG = '0;

  function automatic logic tag_writes(input hz_tag_t t, input logic [PKG_REG_AW-1:0] a);
    return t.valid & t.we & (t.addr == a);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// One decode operand mux: picks the youngest in-flight producer of rs_addr,
// or the register-file value when nothing in flight writes it.
//   rs_addr    : source register address
//   rs_re      : read enable (disabled reads and x0 return zero)
//   tag_vec    : STAGES packed hz_tag_t, stage 0 (EX) in the LSBs
//   stage_data : STAGES result words, stage 0 in the LSBs
//   rf_data    : register-file read data for this port
//   operand    : forwarded operand
module pipe_hazard_ctrl_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = PKG_XLEN,
  parameter int unsigned REG_AW = PKG_REG_AW,
  parameter int unsigned STAGES = 3
) (
  input  logic [REG_AW-1:0]       rs_addr,
  input  logic                    rs_re,
  input  logic [STAGES*TAG_W-1:0] tag_vec,
  input  logic [STAGES*XLEN-1:0]  stage_data,
  input  logic [XLEN-1:0]         rf_data,
  output logic [XLEN-1:0]         operand
);

  hz_tag_t t;
  logic    hit;
  // is_load only steers the parent's stage-data mux; it is irrelevant here.
  logic    unused_is_load;

  always_comb begin
    operand        = rf_data;
    hit            = 1'b0;
    t              = BUBBLE_TAG;
    unused_is_load = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      t              = tag_vec[k*TAG_W +: TAG_W];
      unused_is_load = unused_is_load ^ t.is_load;
      // Scan youngest first and latch on the first hit.
      if (!hit && tag_writes(t, rs_addr)) begin
        operand = stage_data[k*XLEN +: XLEN];
        hit     = 1'b1;
      end
    end
    if (!rs_re || rs_addr == '0) begin
      operand = '0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks destination tags through STAGES post-decode stages (EX..WB),
// forwards the youngest matching result to NUM_RS decode read ports,
// stalls ID on load-use, applies flushes and drives register writeback.
//   clk, rst         : clock, synchronous active-low reset
//   id_*             : decode-stage instruction (sources, destination, load)
//   rf_rdata         : register-file read data, port 0 in LSBs
//   ex_result        : combinational EX result of the stage-0 tag
//   mem_load_data    : load data while the stage-1 tag is a load
//   flush, ext_stall : branch kill of ID+EX, whole-pipe freeze
//   id_rs_data       : forwarded operands, id_ready : ID advances
//   wb_we/addr/data  : register-file write port
//   lu_stall_cnt, flush_cnt : saturating event counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = PKG_XLEN,
  parameter int unsigned REG_AW = PKG_REG_AW,
  parameter int unsigned NUM_RS = 2,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_RS-1:0]        id_rs_re,
  input  logic [NUM_RS*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_RS*XLEN-1:0]   rf_rdata,
  input  logic                     id_rd_we,
  input  logic [REG_AW-1:0]        id_rd_addr,
  input  logic                     id_is_load,
  input  logic [XLEN-1:0]          ex_result,
  input  logic [XLEN-1:0]          mem_load_data,
  input  logic                     flush,
  input  logic                     ext_stall,
  output logic [NUM_RS*XLEN-1:0]   id_rs_data,
  output logic                     id_ready,
  output logic                     wb_we,
  output logic [REG_AW-1:0]        wb_addr,
  output logic [XLEN-1:0]          wb_data,
  output logic [CNT_W-1:0]         lu_stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  hz_tag_t [STAGES-1:0]  tag_q;
  logic [XLEN-1:0]       data_q [1:STAGES-1];
  logic [STAGES*XLEN-1:0] stage_data;
  hz_tag_t               id_tag;
  logic                  lu;

  always_comb begin
    id_tag         = BUBBLE_TAG;
    id_tag.valid   = 1'b1;
    id_tag.we      = id_rd_we;
    id_tag.addr    = id_rd_addr;
    id_tag.is_load = id_is_load;
  end

  // Effective result per stage. A load in MEM delivers mem_load_data instead
  // of the address held in D[1]; this one view feeds forwarding, the D[k]
  // shift and writeback so all three agree.
  always_comb begin
    stage_data = '0;
    stage_data[EX_STG*XLEN +: XLEN] = ex_result;
    for (int unsigned k = 1; k < STAGES; k++) begin
      stage_data[k*XLEN +: XLEN] = data_q[k];
    end
    if (tag_q[MEM_STG].is_load) begin
      stage_data[MEM_STG*XLEN +: XLEN] = mem_load_data;
    end
  end

  always_comb begin
    lu = 1'b0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (id_valid && id_rs_re[i] && tag_q[EX_STG].is_load &&
          id_rs_addr[i*REG_AW +: REG_AW] != '0 &&
          tag_writes(tag_q[EX_STG], id_rs_addr[i*REG_AW +: REG_AW])) begin
        lu = 1'b1;
      end
    end
  end

  assign id_ready = !lu && !ext_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q        <= '0;
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (!ext_stall) begin
        for (int unsigned k = 2; k < STAGES; k++) begin
          tag_q[k]  <= tag_q[k-1];
          data_q[k] <= stage_data[(k-1)*XLEN +: XLEN];
        end
        // A taken branch kills both the ID and the EX instruction.
        tag_q[MEM_STG]  <= flush ? BUBBLE_TAG : tag_q[EX_STG];
        data_q[MEM_STG] <= ex_result;
        tag_q[EX_STG]   <= (id_valid && !lu && !flush) ? id_tag : BUBBLE_TAG;
        if (lu && lu_stall_cnt != '1) begin
          lu_stall_cnt <= lu_stall_cnt + 1'b1;
        end
      end
      // Flushes are counted even while frozen; the owner re-issues them.
      if (flush && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign wb_we   = tag_q[STAGES-1].valid && tag_q[STAGES-1].we &&
                   tag_q[STAGES-1].addr != '0 && !ext_stall;
  assign wb_addr = tag_q[STAGES-1].addr;
  assign wb_data = stage_data[(STAGES-1)*XLEN +: XLEN];

  for (genvar i = 0; i < NUM_RS; i++) begin : g_fwd
    pipe_hazard_ctrl_fwd_sel #(
      .XLEN  (XLEN),
      .REG_AW(REG_AW),
      .STAGES(STAGES)
    ) u_fwd (
      .rs_addr   (id_rs_addr[i*REG_AW +: REG_AW]),
      .rs_re     (id_rs_re[i]),
      .tag_vec   (tag_q),
      .stage_data(stage_data),
      .rf_data   (rf_rdata[i*XLEN +: XLEN]),
      .operand   (id_rs_data[i*XLEN +: XLEN])
    );
  end

endmodule
